// File: rtl/tm1638_pkg.sv
// Shared definitions for the TM1638-style serial display/keypad responder.
package tm1638_pkg;

    // Command class, taken from bits [7:6] of the first byte after STB falls.
    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_DATA = 2'b01;
    localparam logic [1:0] CMD_DISP = 2'b10;
    localparam logic [1:0] CMD_ADDR = 2'b11;

    // Bit positions inside a data command byte.
    localparam int DATA_RD_BIT    = 1;
    localparam int DATA_FIXED_BIT = 2;

    // Bit position of the enable flag inside a display-control byte.
    localparam int DISP_ON_BIT = 3;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WRITE,
        READ,
        DISCARD
    } state_t;

endpackage

// File: rtl/tm_pin_sync.sv
// Multi-flop synchronizer for one asynchronous pin, with edge detection.
// The chain resets low, so a pin that is already low when reset releases
// produces no falling edge until it has first been seen high.
module tm_pin_sync #(
    parameter int STAGES = 2    // must be at least 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the pin through the synchronizer chain and keep the previous level.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments let every flop sample its input
        // before any of them update, which is what makes the chain a chain.
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pin};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/tm1638_responder.sv
// Device-side model of a TM1638-style STB/CLK/DIO link: decodes commands into
// a 16-byte display RAM and display-control settings, and shifts a keypad
// snapshot back out on DIO.
module tm1638_responder
    import tm1638_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tm_stb,
    input  logic        tm_clk,
    input  logic        tm_dio_in,
    output logic        tm_dio_out,
    output logic        tm_dio_oe,
    input  logic [31:0] key_data,
    input  logic [3:0]  disp_addr,
    output logic [7:0]  disp_data,
    output logic        disp_on,
    output logic [2:0]  brightness,
    output logic        frame_done
);

    logic stb_rise, stb_fall, clk_rise, clk_fall, dio_lvl;
    logic stb_level_unused, clk_level_unused, dio_rise_unused, dio_fall_unused;

    tm_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_stb (
        .clk(clk), .reset(reset), .pin(tm_stb),
        .level(stb_level_unused), .rise(stb_rise), .fall(stb_fall)
    );

    tm_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (
        .clk(clk), .reset(reset), .pin(tm_clk),
        .level(clk_level_unused), .rise(clk_rise), .fall(clk_fall)
    );

    tm_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_dio (
        .clk(clk), .reset(reset), .pin(tm_dio_in),
        .level(dio_lvl), .rise(dio_rise_unused), .fall(dio_fall_unused)
    );

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic [3:0]  addr_q;
    logic        rd_q, fixed_q;
    logic        disp_on_q;
    logic [2:0]  brightness_q;
    logic        pending_q, frame_done_q;
    logic [31:0] key_snap_q;
    logic [4:0]  rd_idx_q, rd_idx_next;
    logic        seen_rise_q;
    logic        dio_oe_q, dio_out_q;
    logic [7:0]  ram_q [16];

    // Byte assembly: bits arrive LSB first, so new bits enter at the top.
    logic [7:0] byte_d;
    logic       byte_done;

    assign byte_d      = {dio_lvl, shift_q[7:1]};
    assign byte_done   = clk_rise && !stb_rise && (bit_cnt_q == 3'd7)
                         && (state_q == CMD || state_q == WRITE);
    assign rd_idx_next = rd_idx_q + 5'd1;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode; an STB rise overrides everything else.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch forms.
        state_d = state_q;
        unique case (state_q)
            IDLE: if (stb_fall) state_d = CMD;
            CMD: begin
                if (byte_done) begin
                    unique case (byte_d[7:6])
                        CMD_DATA: state_d = byte_d[DATA_RD_BIT] ? READ : DISCARD;
                        CMD_ADDR: state_d = WRITE;
                        default:  state_d = DISCARD;
                    endcase
                end
            end
            default: ;
        endcase
        if (stb_rise) state_d = IDLE;
    end

    // Datapath: shifting, command decode, RAM writes, read-back and frame pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            addr_q       <= '0;
            rd_q         <= 1'b0;
            fixed_q      <= 1'b0;
            disp_on_q    <= 1'b0;
            brightness_q <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            key_snap_q   <= '0;
            rd_idx_q     <= '0;
            seen_rise_q  <= 1'b0;
            dio_oe_q     <= 1'b0;
            dio_out_q    <= 1'b1;
            // NOTE: the RAM is built from flops rather than a memory macro
            // precisely so that reset can clear every byte.
            for (int i = 0; i < 16; i++) ram_q[i] <= '0;
        end else begin
            frame_done_q <= 1'b0;
            if (stb_rise) begin
                frame_done_q <= pending_q;
                pending_q    <= 1'b0;
                dio_oe_q     <= 1'b0;
                dio_out_q    <= 1'b1;
                bit_cnt_q    <= '0;
            end else begin
                unique case (state_q)
                    IDLE: if (stb_fall) bit_cnt_q <= '0;
                    CMD, WRITE: begin
                        if (clk_rise) begin
                            shift_q   <= byte_d;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                        if (byte_done && state_q == CMD) begin
                            unique case (byte_d[7:6])
                                CMD_DATA: begin
                                    rd_q    <= byte_d[DATA_RD_BIT];
                                    fixed_q <= byte_d[DATA_FIXED_BIT];
                                    if (byte_d[DATA_RD_BIT]) key_snap_q <= key_data;
                                end
                                CMD_ADDR: addr_q <= byte_d[3:0];
                                CMD_DISP: begin
                                    disp_on_q    <= byte_d[DISP_ON_BIT];
                                    brightness_q <= byte_d[2:0];
                                end
                                default: ;
                            endcase
                        end
                        if (byte_done && state_q == WRITE) begin
                            ram_q[addr_q] <= byte_d;
                            pending_q     <= 1'b1;
                            if (!fixed_q) addr_q <= addr_q + 4'd1;
                        end
                    end
                    READ: begin
                        if (!dio_oe_q && rd_q) begin
                            // First cycle in READ: present bit 0 of the snapshot.
                            dio_oe_q    <= 1'b1;
                            dio_out_q   <= key_snap_q[0];
                            rd_idx_q    <= '0;
                            seen_rise_q <= 1'b0;
                        end else if (clk_rise) begin
                            seen_rise_q <= 1'b1;
                        end else if (clk_fall && seen_rise_q) begin
                            rd_idx_q    <= rd_idx_next;
                            dio_out_q   <= key_snap_q[rd_idx_next];
                            seen_rise_q <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign disp_data  = ram_q[disp_addr];
    assign disp_on    = disp_on_q;
    assign brightness = brightness_q;
    assign frame_done = frame_done_q;
    assign tm_dio_oe  = dio_oe_q;
    assign tm_dio_out = dio_out_q;

endmodule
